scoreboard_reg_file: RTL and testbench
======================================

// Module: scoreboard_reg_file
// PURPOSE
//  Parametrised architectural register file with a counting scoreboard, N read ports and same-cycle WB bypass.
//  Sits between decode (issue/read) and writeback; replaces the single-busy-bit scheme.
//  Per-register pending-write counters allow multiple in-flight writers.
//  A flush port clears all pending state on pipeline redirect.
// PARAMETERS
//  ADDR_WIDTH  5   register index width (2**ADDR_WIDTH registers)
//  DATA_WIDTH  64  register data width
//  NUM_READ    2   number of read ports (1..4)
//  CNT_WIDTH   2   pending-write counter width; max in-flight writers per reg = 2**CNT_WIDTH-1
//  SP_INDEX    2   register loaded from stackptr at reset
// PORTS
//  clk          in   1                     clock, all state updates on posedge
//  reset_n      in   1                     synchronous reset, active low
//  stackptr     in   DATA_WIDTH            reset value for x[SP_INDEX]
//  rs_addr      in   NUM_READ*ADDR_WIDTH   read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  rs_data      out  NUM_READ*DATA_WIDTH   read data, same packing
//  rs_busy      out  NUM_READ              port i source has pending writer(s)
//  raw_hazard   out  1                     OR of rs_busy
//  issue_valid  in   1                     decode schedules a write to issue_addr
//  issue_addr   in   ADDR_WIDTH            destination being scheduled
//  issue_ready  out  1                     issue_addr counter not saturated (x0 always ready)
//  wb_valid     in   1                     writeback writes wb_data to wb_addr
//  wb_addr      in   ADDR_WIDTH            writeback destination
//  wb_data      in   DATA_WIDTH            writeback data
//  wb_done      out  1                     registered pulse: a non-x0 write happened last cycle
//  flush        in   1                     clear all pending counters
//  sb_error     out  1                     sticky: writeback to reg with counter 0 (non-flush)
//  dbg_busy     out  2**ADDR_WIDTH         per-register (counter != 0) mask
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): x[SP_INDEX]<=stackptr, all other regs 0, all counters 0,
//   wb_done 0, sb_error 0. Reset wins over every other input.
//  Reads: combinational. x0 reads 0, never busy. rs_busy[i] = (addr!=0) && cnt[addr]!=0.
//  Issue: accepted iff issue_valid && issue_ready; accepted issue -> cnt[issue_addr]+1 next cycle.
//   issue_ready = (issue_addr==0) || cnt[issue_addr] != max; unaccepted issue is dropped (decode stalls).
//   Issue to x0: accepted, no state change.
//  Writeback: wb_valid && wb_addr!=0 -> reg <= wb_data next cycle; wb_done=1 the following cycle.
//   cnt[wb_addr] decrements; if cnt already 0: no decrement (saturate), sb_error<=1 unless flush.
//  Same-reg issue + WB same cycle: data written, counter unchanged (net +1-1); no sb_error even if cnt==0.
//  Different-reg issue + WB same cycle: both applied independently.
//  Flush: all counters <=0 next cycle, overriding same-cycle issue/WB counter updates;
//   WB data write still performed; sb_error not set that cycle.
//  Counter arithmetic: unsigned CNT_WIDTH, never wraps (issue_ready blocks overflow, WB saturates at 0).
//  dbg_busy[0] always 0. No other latency: reads see register array state of current cycle.
// CONFIGURATION
//  WB_BYPASS_EN defined: if wb_valid && wb_addr==rs_addr[i] && wb_addr!=0, rs_data[i]=wb_data
//   same cycle; rs_busy[i] is also cleared when cnt==1 (last writer retiring now).
//  WB_BYPASS_EN undefined: rs_data is array contents only; rs_busy uses cnt alone, value visible
//   one cycle after writeback.
// TESTING
//  Reset with stackptr=0x8000 -> x2 reads 0x8000, x5 reads 0, raw_hazard=0, dbg_busy=0, sb_error=0.
//  Issue x5; next cycle rs_addr0=5 -> rs_busy[0]=1, raw_hazard=1; WB x5=0xAA -> next cycle busy=0, x5=0xAA, wb_done=1.
//  Issue x7 three times (CNT_WIDTH=2) -> issue_ready=0 for x7; 4th issue dropped; 3 WBs -> busy clears only after the 3rd.
//  Same cycle issue x9 + WB x9=0x11 with cnt=1 -> cnt stays 1, x9=0x11, sb_error=0.
//  Issue x3,x4; flush with same-cycle issue x6 -> dbg_busy=0 next cycle; later WB x3 sets sb_error=1.
//  WB x8=0x55 with rs_addr1=8, cnt=1: WB_BYPASS_EN -> rs_data1=0x55, rs_busy[1]=0 same cycle; else old value, busy=1.
//  Issue/WB to x0 with wb_data=0xFF -> x0 reads 0, wb_done=0, no busy, sb_error=0.

Source files
------------

// File: rtl/scoreboard_reg_file.sv
// -----------------------------------------------------------------------------
// scoreboard_reg_file
//   Architectural register file with a counting scoreboard. Each register has
//   a small pending-write counter, so several writers can be in flight to the
//   same destination at once. Sits between decode (issue/read) and writeback.
//   Reads are combinational. A flush clears every pending counter on a
//   pipeline redirect.
//
// Optional feature macro: WB_BYPASS_EN
//   Defined   : a same-cycle writeback to a read address is forwarded onto
//               rs_data. rs_busy drops early when that writeback retires the
//               last pending writer.
//   Undefined : rs_data shows array contents only. rs_busy follows the
//               counter alone.
//
// Ports
//   clk          clock, all state updates on posedge
//   reset_n      synchronous reset, active low
//   stackptr     reset value loaded into x[SP_INDEX]
//   rs_addr      packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rs_data      packed read data, same packing
//   rs_busy      per read port: source has pending writer(s)
//   raw_hazard   OR of rs_busy
//   issue_valid  decode schedules a write to issue_addr
//   issue_addr   destination being scheduled
//   issue_ready  issue_addr counter not saturated (x0 always ready)
//   wb_valid     writeback writes wb_data to wb_addr
//   wb_addr      writeback destination
//   wb_data      writeback data
//   wb_done      registered pulse: a non-x0 write happened last cycle
//   flush        clear all pending counters
//   sb_error     sticky: writeback to a register whose counter was 0
//   dbg_busy     per-register (counter != 0) mask
// -----------------------------------------------------------------------------
module scoreboard_reg_file #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_READ   = 2,
  parameter int CNT_WIDTH  = 2,
  parameter int SP_INDEX   = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [DATA_WIDTH-1:0]            stackptr,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   rs_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]   rs_data,
  output logic [NUM_READ-1:0]              rs_busy,
  output logic                             raw_hazard,
  input  logic                             issue_valid,
  input  logic [ADDR_WIDTH-1:0]            issue_addr,
  output logic                             issue_ready,
  input  logic                             wb_valid,
  input  logic [ADDR_WIDTH-1:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0]            wb_data,
  output logic                             wb_done,
  input  logic                             flush,
  output logic                             sb_error,
  output logic [(2**ADDR_WIDTH)-1:0]       dbg_busy
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [CNT_WIDTH-1:0]  r_cnt  [NUM_REGS];
  logic                  r_wb_done;
  logic                  r_sb_error;

  logic [CNT_WIDTH-1:0]  w_cnt_nxt [NUM_REGS];
  logic                  w_issue_acc;
  logic                  w_wb_act;
  logic                  w_same_reg;
  logic                  w_sb_err_set;

  // Issue acceptance, writeback activity and the error condition.
  always_comb begin
    issue_ready  = (issue_addr == {ADDR_WIDTH{1'b0}}) || (r_cnt[issue_addr] != CNT_MAX);
    // Issue to x0 is accepted but tracks nothing, so it is not counted here.
    w_issue_acc  = issue_valid && issue_ready && (issue_addr != {ADDR_WIDTH{1'b0}});
    w_wb_act     = wb_valid && (wb_addr != {ADDR_WIDTH{1'b0}});
    // Same register scheduled and retired together: net counter change is zero.
    w_same_reg   = w_issue_acc && w_wb_act && (issue_addr == wb_addr);
    w_sb_err_set = w_wb_act && (r_cnt[wb_addr] == {CNT_WIDTH{1'b0}}) && !flush && !w_same_reg;
  end

  // Next-state for every pending-write counter. Flush overrides issue and WB.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (flush) begin
        w_cnt_nxt[i] = {CNT_WIDTH{1'b0}};
      end else if (w_same_reg) begin
        w_cnt_nxt[i] = r_cnt[i];
      end else if (w_issue_acc && (issue_addr == ADDR_WIDTH'(i))) begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
      end else if (w_wb_act && (wb_addr == ADDR_WIDTH'(i)) && (r_cnt[i] != {CNT_WIDTH{1'b0}})) begin
        // A WB to a zero counter saturates at 0 instead of wrapping.
        w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
    end
  end

  // Combinational read ports, with optional same-cycle writeback forwarding.
  always_comb begin
    rs_data = {(NUM_READ*DATA_WIDTH){1'b0}};
    rs_busy = {NUM_READ{1'b0}};
    for (int p = 0; p < NUM_READ; p++) begin
      if (rs_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == {ADDR_WIDTH{1'b0}}) begin
        rs_data[p*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
        rs_busy[p] = 1'b0;
      end else begin
        rs_data[p*DATA_WIDTH +: DATA_WIDTH] = r_regs[rs_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
        rs_busy[p] = (r_cnt[rs_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] != {CNT_WIDTH{1'b0}});
`ifdef WB_BYPASS_EN
        if (w_wb_act && (wb_addr == rs_addr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
          rs_data[p*DATA_WIDTH +: DATA_WIDTH] = wb_data;
          // The retiring writeback is the last outstanding writer.
          if (r_cnt[wb_addr] == CNT_ONE) begin
            rs_busy[p] = 1'b0;
          end else begin
            rs_busy[p] = (r_cnt[wb_addr] != {CNT_WIDTH{1'b0}});
          end
        end else begin
          rs_busy[p] = (r_cnt[rs_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] != {CNT_WIDTH{1'b0}});
        end
`endif
      end
    end
    raw_hazard = |rs_busy;
  end

  // Per-register busy mask. x0 is never busy.
  always_comb begin
    dbg_busy = {NUM_REGS{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      dbg_busy[i] = (r_cnt[i] != {CNT_WIDTH{1'b0}});
    end
  end

  // Register array, counters and status flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= (i == SP_INDEX) ? stackptr : {DATA_WIDTH{1'b0}};
        r_cnt[i]  <= {CNT_WIDTH{1'b0}};
      end
      r_wb_done  <= 1'b0;
      r_sb_error <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      // The data write happens even on a flush cycle.
      if (w_wb_act) begin
        r_regs[wb_addr] <= wb_data;
      end
      r_wb_done <= w_wb_act;
      if (w_sb_err_set) begin
        r_sb_error <= 1'b1;
      end
    end
  end

  assign wb_done  = r_wb_done;
  assign sb_error = r_sb_error;

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// -----------------------------------------------------------------------------
// tb_scoreboard_reg_file
//   Self-checking bench for scoreboard_reg_file in its default configuration.
//   A behavioural model predicts every output each cycle. The predictions are
//   queued and then compared against the DUT. Directed checks follow the
//   documented scenarios, and a random phase follows them.
// -----------------------------------------------------------------------------
module tb_scoreboard_reg_file;

  localparam int AW   = 5;
  localparam int DW   = 64;
  localparam int NR   = 2;
  localparam int CW   = 2;
  localparam int NREG = 32;
  localparam int CMAX = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [DW-1:0]     stackptr;
  logic [NR*AW-1:0]  rs_addr;
  logic [NR*DW-1:0]  rs_data;
  logic [NR-1:0]     rs_busy;
  logic              raw_hazard;
  logic              issue_valid;
  logic [AW-1:0]     issue_addr;
  logic              issue_ready;
  logic              wb_valid;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
  logic              wb_done;
  logic              flush;
  logic              sb_error;
  logic [NREG-1:0]   dbg_busy;

  always #5 clk = ~clk;

  scoreboard_reg_file #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .CNT_WIDTH(CW), .SP_INDEX(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .stackptr(stackptr),
    .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy), .raw_hazard(raw_hazard),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_done(wb_done),
    .flush(flush), .sb_error(sb_error), .dbg_busy(dbg_busy)
  );

  int checks_cnt = 0;
  int fail_cnt   = 0;

  // Reference model state.
  logic [DW-1:0] m_regs [NREG];
  int            m_cnt  [NREG];
  logic          m_done;
  logic          m_err;

  // Scoreboard of pending expectations.
  logic [63:0] exp_q [$];
  string       tag_q [$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_of(input string tag);
    if (tag == "rs_data0")         return rs_data[63:0];
    else if (tag == "rs_data1")    return rs_data[127:64];
    else if (tag == "rs_busy")     return 64'(rs_busy);
    else if (tag == "raw_hazard")  return 64'(raw_hazard);
    else if (tag == "issue_ready") return 64'(issue_ready);
    else if (tag == "dbg_busy")    return 64'(dbg_busy);
    else if (tag == "wb_done")     return 64'(wb_done);
    else if (tag == "sb_error")    return 64'(sb_error);
    else                           return {64{1'bx}};
  endfunction

  task automatic push_exp(input string tag, input logic [63:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic drain();
    string       t;
    logic [63:0] e;
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check_val(t, obs_of(t), e);
    end
  endtask

  // Predict all outputs from the model and the current inputs.
  task automatic predict();
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    logic            b;
    logic [NR-1:0]   busy_v;
    logic [NREG-1:0] dbg;
    for (int p = 0; p < NR; p++) begin
      a = rs_addr[p*AW +: AW];
      d = (a == 5'd0) ? 64'd0 : m_regs[a];
      b = (a != 5'd0) && (m_cnt[a] != 0);
`ifdef WB_BYPASS_EN
      if (wb_valid && (wb_addr == a) && (a != 5'd0)) begin
        d = wb_data;
        if (m_cnt[a] == 1) b = 1'b0;
      end
`endif
      push_exp($sformatf("rs_data%0d", p), d);
      busy_v[p] = b;
    end
    dbg = '0;
    for (int i = 1; i < NREG; i++) dbg[i] = (m_cnt[i] != 0);
    push_exp("rs_busy", 64'(busy_v));
    push_exp("raw_hazard", 64'(|busy_v));
    push_exp("issue_ready", 64'((issue_addr == 5'd0) || (m_cnt[issue_addr] != CMAX)));
    push_exp("dbg_busy", 64'(dbg));
    push_exp("wb_done", 64'(m_done));
    push_exp("sb_error", 64'(m_err));
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_clock();
    logic rdy, acc, wba, same;
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = 64'd0;
        m_cnt[i]  = 0;
      end
      m_regs[2] = stackptr;
      m_done = 1'b0;
      m_err  = 1'b0;
    end else begin
      rdy  = (issue_addr == 5'd0) || (m_cnt[issue_addr] != CMAX);
      acc  = issue_valid && rdy;
      wba  = wb_valid && (wb_addr != 5'd0);
      same = acc && wba && (issue_addr == wb_addr);
      if (wba && (m_cnt[wb_addr] == 0) && !flush && !same) m_err = 1'b1;
      if (flush) begin
        for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
      end else if (!same) begin
        if (acc && (issue_addr != 5'd0)) m_cnt[issue_addr] = m_cnt[issue_addr] + 1;
        if (wba && (m_cnt[wb_addr] > 0)) m_cnt[wb_addr] = m_cnt[wb_addr] - 1;
      end
      if (wba) m_regs[wb_addr] = wb_data;
      m_done = wba;
    end
  endtask

  // One checked cycle: inputs were driven at the preceding negedge.
  task automatic tick();
    #1;
    predict();
    drain();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic reset_cycle();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_addr  = 5'd0;
    wb_valid    = 1'b0;
    wb_addr     = 5'd0;
    wb_data     = 64'd0;
    flush       = 1'b0;
  endtask

  initial begin
    idle();
    reset_n  = 1'b0;
    stackptr = 64'h8000;
    rs_addr  = {5'd5, 5'd2};
    @(negedge clk);
    reset_cycle();
    reset_cycle();
    reset_n = 1'b1;

    // Reset state.
    #1;
    check_val("x2_reset", rs_data[63:0], 64'h8000);
    check_val("x5_reset", rs_data[127:64], 64'h0);
    check_val("dbg_reset", 64'(dbg_busy), 64'h0);
    tick();

    // Issue x5, read it back as busy, then retire it.
    issue_valid = 1'b1; issue_addr = 5'd5; rs_addr = {5'd0, 5'd5};
    tick();
    idle();
    #1;
    check_val("x5_busy", 64'(rs_busy[0]), 64'h1);
    check_val("x5_raw", 64'(raw_hazard), 64'h1);
    tick();
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 64'hAA;
    tick();
    idle();
    #1;
    check_val("x5_data", rs_data[63:0], 64'hAA);
    check_val("x5_done", 64'(wb_done), 64'h1);
    check_val("x5_idle", 64'(rs_busy[0]), 64'h0);
    tick();

    // Three writers to x7 saturate the counter, so the fourth issue is dropped.
    rs_addr = {5'd0, 5'd7};
    for (int k = 0; k < 3; k++) begin
      issue_valid = 1'b1; issue_addr = 5'd7;
      tick();
    end
    #1;
    check_val("x7_full", 64'(issue_ready), 64'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      issue_valid = 1'b0;
      wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 64'(k + 100);
      tick();
      idle();
      #1;
      check_val($sformatf("x7_busy_wb%0d", k), 64'(rs_busy[0]), (k < 2) ? 64'h1 : 64'h0);
    end
    tick();

    // Same-cycle issue and writeback to x9 leaves the counter at 1.
    rs_addr = {5'd0, 5'd9};
    issue_valid = 1'b1; issue_addr = 5'd9;
    tick();
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 64'h11;
    tick();
    idle();
    #1;
    check_val("x9_data", rs_data[63:0], 64'h11);
    check_val("x9_cnt", 64'(dbg_busy[9]), 64'h1);
    check_val("x9_err", 64'(sb_error), 64'h0);
    tick();

    // Writeback to x8 while port 1 reads it with one pending writer.
    issue_valid = 1'b1; issue_addr = 5'd8;
    tick();
    idle();
    rs_addr = {5'd8, 5'd0};
    wb_valid = 1'b1; wb_addr = 5'd8; wb_data = 64'h55;
    #1;
`ifdef WB_BYPASS_EN
    check_val("x8_byp_data", rs_data[127:64], 64'h55);
    check_val("x8_byp_busy", 64'(rs_busy[1]), 64'h0);
`else
    check_val("x8_nobyp_data", rs_data[127:64], 64'h0);
    check_val("x8_nobyp_busy", 64'(rs_busy[1]), 64'h1);
`endif
    tick();
    idle();
    tick();

    // Issue and writeback to x0 have no visible effect.
    rs_addr = {5'd0, 5'd0};
    issue_valid = 1'b1; issue_addr = 5'd0;
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 64'hFF;
    #1;
    check_val("x0_ready", 64'(issue_ready), 64'h1);
    tick();
    idle();
    #1;
    check_val("x0_data", rs_data[63:0], 64'h0);
    check_val("x0_done", 64'(wb_done), 64'h0);
    check_val("x0_err", 64'(sb_error), 64'h0);
    tick();

    // A flush overrides a same-cycle issue, and the next WB raises sb_error.
    issue_valid = 1'b1; issue_addr = 5'd3;
    tick();
    issue_addr = 5'd4;
    tick();
    issue_addr = 5'd6; flush = 1'b1;
    tick();
    idle();
    #1;
    check_val("flush_dbg", 64'(dbg_busy), 64'h0);
    tick();
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 64'h33;
    tick();
    idle();
    #1;
    check_val("flush_err", 64'(sb_error), 64'h1);
    tick();

    // Random traffic on a small register window.
    for (int n = 0; n < 300; n++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_addr  = 5'($urandom_range(0, 7));
      wb_valid    = 1'($urandom_range(0, 1));
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = {$urandom, $urandom};
      flush       = ($urandom_range(0, 15) == 0);
      rs_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      tick();
    end

    // A reset in mid-run restores the initial state.
    idle();
    stackptr = 64'h1234;
    reset_n  = 1'b0;
    reset_cycle();
    reset_n = 1'b1;
    rs_addr = {5'd3, 5'd2};
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
